// File: rtl/data_memory_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, captured op codes, default width.
package data_memory_responder_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_ADR = 4'b1100,
    OP_LDR = 4'b1101,
    OP_STR = 4'b1110
  } op_t;

endpackage

// File: rtl/data_memory_responder_ram_array.sv
// Single-port word RAM with registered read; read data appears one edge after addr.
// No reset on contents or read register; the owner gates we.
module dmem_ram_array
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_BITS  = 8,
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_BITS)-1];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_memory_responder.sv
// Responder for CPU data-memory requests: capture, WAIT_STATES wait cycles, one access cycle,
// then mem_ready held until the requester drops LDR/STR (ready WAIT_STATES+1 edges after capture).
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int ADDR_BITS   = 8,
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int WAIT_STATES = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [31:0]           address_in,
  input  logic                  RW,
  input  logic                  LDR,
  input  logic                  STR,
  input  logic [DATA_WIDTH-1:0] STR_data,
  output logic [DATA_WIDTH-1:0] LDR_out,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  addr_err
);

  state_t                state;
  op_t                   op_q;
  logic [2:0]            cnt_q;
  logic [ADDR_BITS-1:0]  addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  err_q;

  logic                  is_ld;
  logic                  is_st;
  logic                  in_range;
  logic [ADDR_BITS-1:0]  ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign is_ld    = LDR & ~STR & RW;
  assign is_st    = STR & ~LDR & ~RW;
  assign in_range = (address_in >> ADDR_BITS) == 32'd0;

  // In IDLE the RAM is addressed straight from the request so that the read
  // launched on the capture edge is already valid when WAIT_STATES is zero.
  assign ram_addr = (state == IDLE) ? address_in[ADDR_BITS-1:0] : addr_q;
  assign ram_we   = (state == ACCESS) && (op_q == OP_STR) && !err_q && !Reset;

  dmem_ram_array #(
    .ADDR_BITS (ADDR_BITS),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_ram (
    .clk  (Clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(data_q),
    .rdata(ram_rdata)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      op_q      <= OP_ADR;
      cnt_q     <= 3'd0;
      addr_q    <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      LDR_out   <= '0;
      mem_ready <= 1'b0;
      mem_busy  <= 1'b0;
      addr_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (LDR || STR) begin
            addr_q   <= address_in[ADDR_BITS-1:0];
            data_q   <= STR_data;
            op_q     <= is_ld ? OP_LDR : (is_st ? OP_STR : OP_ADR);
            err_q    <= !(is_ld || is_st) || !in_range;
            mem_busy <= 1'b1;
            if (WAIT_STATES > 0) begin
              cnt_q <= 3'(WAIT_STATES);
              state <= WAIT;
            end else begin
              state <= ACCESS;
            end
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 3'd1;
          if (cnt_q == 3'd1) state <= ACCESS;
        end
        ACCESS: begin
          // An illegal strobe combination returns zero data; an out-of-range store leaves it alone.
          if (op_q == OP_LDR)      LDR_out <= err_q ? '0 : ram_rdata;
          else if (op_q == OP_ADR) LDR_out <= '0;
          mem_ready <= 1'b1;
          addr_err  <= err_q;
          mem_busy  <= 1'b0;
          state     <= DONE;
        end
        DONE: begin
          if (!LDR && !STR) begin
            mem_ready <= 1'b0;
            addr_err  <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
